// File: rtl/up_bus_arbiter.sv
// Two-master up bus arbiter: holds one pending write and one pending read per requester,
// issues them one at a time downstream and returns each ack, or a timeout, to its owner.
module up_bus_arbiter #(
    parameter int unsigned ADDRESS_WIDTH  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hdead_dead
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     a_wreq,
    input  logic [ADDRESS_WIDTH-1:0] a_waddr,
    input  logic [31:0]              a_wdata,
    output logic                     a_wack,
    input  logic                     a_rreq,
    input  logic [ADDRESS_WIDTH-1:0] a_raddr,
    output logic [31:0]              a_rdata,
    output logic                     a_rack,
    input  logic                     b_wreq,
    input  logic [ADDRESS_WIDTH-1:0] b_waddr,
    input  logic [31:0]              b_wdata,
    output logic                     b_wack,
    input  logic                     b_rreq,
    input  logic [ADDRESS_WIDTH-1:0] b_raddr,
    output logic [31:0]              b_rdata,
    output logic                     b_rack,
    output logic                     dn_wreq,
    output logic [ADDRESS_WIDTH-1:0] dn_waddr,
    output logic [31:0]              dn_wdata,
    input  logic                     dn_wack,
    output logic                     dn_rreq,
    output logic [ADDRESS_WIDTH-1:0] dn_raddr,
    input  logic [31:0]              dn_rdata,
    input  logic                     dn_rack,
    output logic                     grant_b,
    output logic                     timeout,
    output logic                     overlap_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e                   r_state;
    logic [CW-1:0]            r_cnt;
    logic                     r_last_b;
    logic                     r_own_b;
    logic                     r_is_read;

    logic                     r_aw_v, r_ar_v, r_bw_v, r_br_v;
    logic [ADDRESS_WIDTH-1:0] r_aw_addr, r_ar_addr, r_bw_addr, r_br_addr;
    logic [31:0]              r_aw_data, r_bw_data;

    logic        w_ack_hit, w_to_hit, w_done;
    logic        w_clr_aw, w_clr_ar, w_clr_bw, w_clr_br;
    logic        w_ld_aw, w_ld_ar, w_ld_bw, w_ld_br;
    logic        w_ovl, w_a_work, w_b_work, w_pick_b, w_pick_rd;
    logic [31:0] w_rd_data;

    always_comb begin
        w_ack_hit = (r_state == StWait) && (r_is_read ? dn_rack : dn_wack);
        w_to_hit  = (r_state == StWait) && !w_ack_hit && (r_cnt == CntLast);
        w_done    = w_ack_hit || w_to_hit;
        w_clr_aw  = w_done && !r_own_b && !r_is_read;
        w_clr_ar  = w_done && !r_own_b && r_is_read;
        w_clr_bw  = w_done && r_own_b && !r_is_read;
        w_clr_br  = w_done && r_own_b && r_is_read;
        // A slot being retired this edge may be reloaded at the same edge.
        w_ld_aw   = a_wreq && (!r_aw_v || w_clr_aw);
        w_ld_ar   = a_rreq && (!r_ar_v || w_clr_ar);
        w_ld_bw   = b_wreq && (!r_bw_v || w_clr_bw);
        w_ld_br   = b_rreq && (!r_br_v || w_clr_br);
        w_ovl     = (a_wreq && !w_ld_aw) || (a_rreq && !w_ld_ar) ||
                    (b_wreq && !w_ld_bw) || (b_rreq && !w_ld_br);
        w_a_work  = r_aw_v || r_ar_v;
        w_b_work  = r_bw_v || r_br_v;
        w_pick_b  = w_b_work && (!w_a_work || !r_last_b);
        w_pick_rd = w_pick_b ? !r_bw_v : !r_aw_v;
        w_rd_data = w_ack_hit ? dn_rdata : TIMEOUT_DATA;
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_aw_v    <= 1'b0;
            r_ar_v    <= 1'b0;
            r_bw_v    <= 1'b0;
            r_br_v    <= 1'b0;
            r_aw_addr <= '0;
            r_ar_addr <= '0;
            r_bw_addr <= '0;
            r_br_addr <= '0;
            r_aw_data <= '0;
            r_bw_data <= '0;
        end else begin
            if (w_ld_aw) begin
                r_aw_v    <= 1'b1;
                r_aw_addr <= a_waddr;
                r_aw_data <= a_wdata;
            end else if (w_clr_aw) begin
                r_aw_v <= 1'b0;
            end
            if (w_ld_ar) begin
                r_ar_v    <= 1'b1;
                r_ar_addr <= a_raddr;
            end else if (w_clr_ar) begin
                r_ar_v <= 1'b0;
            end
            if (w_ld_bw) begin
                r_bw_v    <= 1'b1;
                r_bw_addr <= b_waddr;
                r_bw_data <= b_wdata;
            end else if (w_clr_bw) begin
                r_bw_v <= 1'b0;
            end
            if (w_ld_br) begin
                r_br_v    <= 1'b1;
                r_br_addr <= b_raddr;
            end else if (w_clr_br) begin
                r_br_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_last_b    <= 1'b1;
            r_own_b     <= 1'b0;
            r_is_read   <= 1'b0;
            dn_wreq     <= 1'b0;
            dn_waddr    <= '0;
            dn_wdata    <= '0;
            dn_rreq     <= 1'b0;
            dn_raddr    <= '0;
            a_wack      <= 1'b0;
            a_rack      <= 1'b0;
            a_rdata     <= '0;
            b_wack      <= 1'b0;
            b_rack      <= 1'b0;
            b_rdata     <= '0;
            grant_b     <= 1'b0;
            timeout     <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            dn_wreq     <= 1'b0;
            dn_rreq     <= 1'b0;
            a_wack      <= 1'b0;
            a_rack      <= 1'b0;
            a_rdata     <= '0;
            b_wack      <= 1'b0;
            b_rack      <= 1'b0;
            b_rdata     <= '0;
            timeout     <= 1'b0;
            overlap_err <= w_ovl;
            unique case (r_state)
                StIdle: begin
                    if (w_a_work || w_b_work) begin
                        r_state   <= StWait;
                        r_cnt     <= '0;
                        r_own_b   <= w_pick_b;
                        r_is_read <= w_pick_rd;
                        grant_b   <= w_pick_b;
                        // Only contested picks move the pointer so conflicts alternate.
                        if (w_a_work && w_b_work) r_last_b <= w_pick_b;
                        if (w_pick_rd) begin
                            dn_rreq  <= 1'b1;
                            dn_raddr <= w_pick_b ? r_br_addr : r_ar_addr;
                        end else begin
                            dn_wreq  <= 1'b1;
                            dn_waddr <= w_pick_b ? r_bw_addr : r_aw_addr;
                            dn_wdata <= w_pick_b ? r_bw_data : r_aw_data;
                        end
                    end
                end
                StWait: begin
                    if (w_done) begin
                        r_state <= StIdle;
                        grant_b <= 1'b0;
                        timeout <= w_to_hit;
                        if (r_own_b) begin
                            b_wack  <= !r_is_read;
                            b_rack  <= r_is_read;
                            b_rdata <= r_is_read ? w_rd_data : 32'd0;
                        end else begin
                            a_wack  <= !r_is_read;
                            a_rack  <= r_is_read;
                            a_rdata <= r_is_read ? w_rd_data : 32'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/up_bus_arbiter.md
# up_bus_arbiter

Two-master arbiter for the up register bus (up_wreq/up_rreq pulse, up_wack/up_rack response) inside the JESD204 TPL cores. Requester A is the host path behind up_axi. Requester B is an internal configuration sequencer, e.g. a profile-switch engine writing up_profile_sel and channel registers. The block captures single-cycle requests from both masters, serialises them onto one downstream bus that feeds the regmap peripherals, and routes each ack and read data back to its originator. A timeout watchdog guarantees that every request gets an ack.

## Interface
- ADDRESS_WIDTH, 10: up bus word address width.
- TIMEOUT_CYCLES, 64: wait-for-ack limit; legal range 2..1024.
- TIMEOUT_DATA, 32'hdead_dead: rdata returned on a timed-out read.

Ports:
- up_clk  in  1  single clock for all logic.
- up_rstn  in  1  asynchronous active-low reset.
- a_wreq / b_wreq  in  1  write request pulse (one cycle).
- a_waddr / b_waddr  in  ADDRESS_WIDTH  write address, valid with wreq.
- a_wdata / b_wdata  in  32  write data, valid with wreq.
- a_wack / b_wack  out  1  write completion pulse.
- a_rreq / b_rreq  in  1  read request pulse.
- a_raddr / b_raddr  in  ADDRESS_WIDTH  read address, valid with rreq.
- a_rdata / b_rdata  out  32  read data, valid only while rack is high, otherwise 0.
- a_rack / b_rack  out  1  read completion pulse.
- dn_wreq, dn_waddr, dn_wdata  out  1/AW/32  downstream write.
- dn_wack  in  1  downstream write ack (OR of peripherals).
- dn_rreq, dn_raddr  out  1/AW  downstream read.
- dn_rdata  in  32  downstream read data, valid with dn_rack.
- dn_rack  in  1  downstream read ack.
- grant_b  out  1  high while B owns the downstream transaction.
- timeout  out  1  one-cycle pulse when a transaction times out.
- overlap_err  out  1  one-cycle pulse when a request hits an already-pending slot.

## Operation
- Four pending slots: A-write, A-read, B-write, B-read. Each slot holds a valid bit, the address, and write data (write slots only). A req pulse loads its slot at the sampling edge.
- A req pulse to a slot that is already valid is dropped. The slot contents stay unchanged and overlap_err pulses.
- FSM states: IDLE, WAIT.
  - IDLE with any slot valid: select a slot, drive dn_wreq or dn_rreq high for exactly one cycle with its address/data, load the timeout counter with 0, go to WAIT.
  - WAIT, ack seen: route the ack to the owner, clear the slot, go to IDLE.
  - WAIT, no ack after TIMEOUT_CYCLES: same as ack seen, plus the timeout pulse.
- Selection is round-robin between requesters. The last_grant register resets to B, so A wins the first conflict after reset. The requester that was not last granted wins when both have work. Within one requester, the write slot is served before the read slot.
- The ack type must match the issued type. dn_rack during a write transaction, or dn_wack during a read, is ignored. Any ack in IDLE is ignored (late ack after timeout).
- Returned read data is dn_rdata on a normal ack and TIMEOUT_DATA on a timeout. Write acks carry no data.
- dn_waddr/dn_wdata/dn_raddr hold their last issued value between requests. They may also read as 0; the bench checks them only while dn_*req is high.
- Reset (asynchronous, mid-operation included) gives:
  - all slots invalid;
  - FSM in IDLE, counter 0, last_grant = B;
  - every output 0, including dn_* buses, rdata, grant_b, timeout, overlap_err.
- A transaction interrupted by reset is lost, with no ack.

## Timing
- All outputs are registered.
- Request to issue: a_wreq high in cycle 0 → slot valid in cycle 1 → dn_wreq high in cycle 2, if the bus is idle.
- Ack return: dn_wack/dn_rack high in cycle m → requester ack high in cycle m+1 with its rdata, FSM back in IDLE in cycle m+1.
- Next issue is no earlier than cycle m+2, so the downstream request rate is at most one per 3 cycles.
- Timeout: the counter is 0 in the cycle dn_*req is high and increments each WAIT cycle.
  - If the counter equals TIMEOUT_CYCLES-1 with no ack, the next cycle carries the requester ack and the timeout pulse.
  - An ack in that same final cycle wins: normal response, no timeout.
- grant_b is high from the dn_*req cycle through the last WAIT cycle.
- A req pulse to a slot in the same cycle that slot's ack is returned is accepted. The slot clears and reloads, with no overlap_err.

## Test plan
- Single A write addr 0x010 data 0x1234_5678, slave acks 3 cycles after dn_wreq → dn_wreq in cycle 2 with matching addr/data; a_wack one cycle after dn_wack; b_wack stays 0.
- A write and B write pulsed in the same cycle after reset → A is issued first, then B; the next simultaneous pair issues B first (round-robin alternates).
- A write and A read in the same cycle, read returns dn_rdata 0xcafe_0001 → write issued first, then read; a_rdata = 0xcafe_0001 only during a_rack.
- B read with no slave ack, TIMEOUT_CYCLES=8 → b_rack and timeout pulse 8 cycles after dn_rreq, b_rdata = 32'hdead_dead; a late dn_rack in IDLE produces no ack.
- Second a_wreq while the A-write slot is pending → overlap_err pulses; the original address/data is issued; only one a_wack.
- up_rstn low during WAIT, then released → all outputs 0 immediately; no ack for the lost transaction; the next request follows cycle-2 issue timing and A wins the first conflict.
